uart_tx_framed: RTL and testbench

//  Parametrised UART transmitter, successor to the fixed 8N1 transmitter.

---
 rtl/uart_pkg.sv | 10 +
 rtl/uart_bit_timer.sv | 32 +++
 rtl/uart_tx_framed.sv | 155 +++++++++++++++
 tb/tb_uart_tx_framed.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the framed UART blocks.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;

    typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD, PAR_NONE2} uart_parity_t;

    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// One-shot bit-period timer: load starts a period of div cycles, bit_done pulses
// on its last cycle. Caller guarantees div >= 1.
module uart_bit_timer #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 bit_done
);

    logic [DIV_WIDTH-1:0] cnt_q;
    logic                 run_q;

    assign bit_done = run_q && (cnt_q == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (load) begin
            cnt_q <= div - DIV_WIDTH'(1);
            run_q <= 1'b1;
        end else if (bit_done) begin
            run_q <= 1'b0;
        end else if (run_q) begin
            cnt_q <= cnt_q - DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_tx_framed.sv
// Framed UART transmitter: runtime divisor, 1/2 stop bits, back-to-back frames.
// Parity support is built only when UART_TX_PARITY_EN is defined.
module uart_tx_framed #(
    parameter int DATA_BITS = 8,
    parameter int DIV_WIDTH = 16,
    parameter int MIN_DIV   = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [DIV_WIDTH-1:0] i_div,
    input  logic                 i_two_stop,
    input  logic [1:0]           i_parity_mode,
    input  logic                 i_stb,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_ack,
    output logic                 o_busy,
    output logic                 o_uart_tx
);
    import uart_pkg::*;

    localparam int                   CNT_W     = $clog2(DATA_BITS + 1);
    localparam logic [DIV_WIDTH-1:0] MIN_DIV_W = DIV_WIDTH'(MIN_DIV);

    uart_tx_state_t       state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 stop2_q, stop2_d;
    logic [DIV_WIDTH-1:0] div_q, div_clamp, timer_div;
    logic                 tx_d, busy_d;
    logic                 accept, load, bit_done;

    assign div_clamp = (i_div < MIN_DIV_W) ? MIN_DIV_W : i_div;
    // A frame accepted on this edge must time its start bit with its own divisor
    assign timer_div = accept ? div_clamp : div_q;

`ifdef UART_TX_PARITY_EN
    uart_parity_t pmode;
    logic         par_q, par_en_q;
    assign pmode = uart_parity_t'(i_parity_mode);
`else
    logic unused_parity;
    assign unused_parity = ^i_parity_mode;
`endif

    uart_bit_timer #(.DIV_WIDTH(DIV_WIDTH)) u_timer (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .load     (load),
        .div      (timer_div),
        .bit_done (bit_done)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        stop2_d   = stop2_q;
        tx_d      = o_uart_tx;
        busy_d    = o_busy;
        accept    = 1'b0;
        load      = 1'b0;
        case (state_q)
            IDLE: accept = i_stb;
            START: if (bit_done) begin
                tx_d      = shreg_q[0];
                shreg_d   = shreg_q >> 1;
                bit_cnt_d = CNT_W'(1);
                load      = 1'b1;
                state_d   = DATA;
            end
            DATA: if (bit_done) begin
                load = 1'b1;
                if (bit_cnt_q == CNT_W'(DATA_BITS)) begin
`ifdef UART_TX_PARITY_EN
                    if (par_en_q) begin
                        tx_d    = par_q;
                        state_d = PARITY;
                    end else
`endif
                    begin
                        tx_d    = UART_IDLE_LEVEL;
                        state_d = STOP;
                    end
                end else begin
                    tx_d      = shreg_q[0];
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_done) begin
                tx_d    = UART_IDLE_LEVEL;
                load    = 1'b1;
                state_d = STOP;
            end
`endif
            STOP: if (bit_done) begin
                if (stop2_q) begin
                    stop2_d = 1'b0;
                    load    = 1'b1;
                end else if (i_stb) begin
                    accept = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            shreg_d   = i_data;
            bit_cnt_d = '0;
            stop2_d   = i_two_stop;
            tx_d      = 1'b0;
            busy_d    = 1'b1;
            load      = 1'b1;
            state_d   = START;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            stop2_q   <= 1'b0;
            div_q     <= MIN_DIV_W;
            o_uart_tx <= UART_IDLE_LEVEL;
            o_busy    <= 1'b0;
            o_ack     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            stop2_q   <= stop2_d;
            o_uart_tx <= tx_d;
            o_busy    <= busy_d;
            o_ack     <= accept;
            if (accept) div_q <= div_clamp;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            par_q    <= 1'b0;
            par_en_q <= 1'b0;
        end else if (accept) begin
            par_q    <= (pmode == PAR_ODD) ? ~^i_data : ^i_data;
            par_en_q <= (pmode == PAR_EVEN) || (pmode == PAR_ODD);
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_framed.sv
// Bench for uart_tx_framed: 8-bit and 7-bit instances checked against a bit-list frame model.
module tb_uart_tx_framed;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] div = 16'd4;
    logic        two_stop = 1'b0;
    logic [1:0]  pm = 2'b00;
    logic        stb8 = 1'b0, stb7 = 1'b0;
    logic [7:0]  data8 = '0;
    logic [6:0]  data7 = '0;
    logic        ack8, busy8, tx8, ack7, busy7, tx7;
    logic        sel = 1'b0;
    int          checks = 0, errors = 0;
    int          eb[$];

    always #5 clk = ~clk;

    wire ack_o  = sel ? ack7  : ack8;
    wire busy_o = sel ? busy7 : busy8;
    wire tx_o   = sel ? tx7   : tx8;

    uart_tx_framed #(.DATA_BITS(8)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_div(div), .i_two_stop(two_stop),
        .i_parity_mode(pm), .i_stb(stb8), .i_data(data8),
        .o_ack(ack8), .o_busy(busy8), .o_uart_tx(tx8));

    uart_tx_framed #(.DATA_BITS(7)) dut7 (
        .i_clk(clk), .i_rst_n(rst_n), .i_div(div), .i_two_stop(two_stop),
        .i_parity_mode(pm), .i_stb(stb7), .i_data(data7),
        .o_ack(ack7), .o_busy(busy7), .o_uart_tx(tx7));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference frame as a list of line levels, one entry per bit period
    task automatic add_frame(input logic [8:0] d, input int nb, input logic [1:0] p, input bit ts);
        int ones = 0;
        eb.push_back(0);
        for (int i = 0; i < nb; i++) begin
            eb.push_back(int'(d[i]));
            ones += int'(d[i]);
        end
`ifdef UART_TX_PARITY_EN
        if (p == 2'b01) eb.push_back(ones % 2);
        if (p == 2'b10) eb.push_back(1 - (ones % 2));
`endif
        eb.push_back(1);
        if (ts) eb.push_back(1);
    endtask

    // Send one word on an idle DUT and check the whole waveform; mid-frame the
    // config inputs are scrambled (div set to chg if chg >= 0).
    task automatic send_check(input bit s, input logic [8:0] d, input int dv, input bit ts,
                              input logic [1:0] p, input int chg, input string tag);
        int ed, total, first;
        ed = (dv < 2) ? 2 : dv;
        eb.delete();
        add_frame(d, s ? 7 : 8, p, ts);
        total = eb.size() * ed;
        first = -1;
        @(negedge clk);
        sel = s; div = 16'(dv); two_stop = ts; pm = p; data8 = d[7:0]; data7 = d[6:0];
        if (s) stb7 = 1'b1; else stb8 = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_ack"}, 32'(ack_o), 32'd1);
        stb8 = 1'b0; stb7 = 1'b0;
        for (int k = 0; k < total; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (k == total / 2) begin
                div = (chg >= 0) ? 16'(chg) : 16'($urandom_range(0, 15));
                two_stop = 1'($urandom); pm = 2'($urandom);
                data8 = 8'($urandom); data7 = 7'($urandom);
            end
            if (first < 0 && (tx_o !== 1'(eb[k / ed]) || busy_o !== 1'b1 || (k > 0 && ack_o !== 1'b0)))
                first = k;
        end
        chk({tag, "_wave_first_bad_cycle"}, 32'(first), 32'hffff_ffff);
        @(posedge clk); #1;
        chk({tag, "_idle_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_idle_tx"}, 32'(tx_o), 32'd1);
    endtask

    initial begin
        int acks, a2, first;
        logic [8:0] rd;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tx8", 32'(tx8), 32'd1);
        chk("rst_busy8", 32'(busy8), 32'd0);
        chk("rst_ack8", 32'(ack8), 32'd0);
        chk("rst_tx7", 32'(tx7), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 8N1 0x55 at div 4
        send_check(1'b0, 9'h055, 4, 1'b0, 2'b00, -1, "t1_8n1");

        // Back-to-back with i_stb held high
        eb.delete();
        add_frame(9'h0A5, 8, 2'b00, 1'b0);
        add_frame(9'h03C, 8, 2'b00, 1'b0);
        acks = 0; a2 = -1; first = -1;
        @(negedge clk);
        sel = 1'b0; div = 16'd12; two_stop = 1'b0; pm = 2'b00; data8 = 8'hA5; stb8 = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 240; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (first < 0 && (tx_o !== 1'(eb[k / 12]) || busy_o !== 1'b1)) first = k;
            if (ack_o === 1'b1) begin
                acks++;
                if (k > 0) begin a2 = k; stb8 = 1'b0; end
                data8 = 8'h3C;
            end
        end
        stb8 = 1'b0;
        chk("t2_wave_first_bad_cycle", 32'(first), 32'hffff_ffff);
        chk("t2_ack_count", 32'(acks), 32'd2);
        chk("t2_second_ack_cycle", 32'(a2), 32'd120);
        @(posedge clk); #1;
        chk("t2_idle_busy", 32'(busy_o), 32'd0);

        // 7-bit, odd parity, two stop bits
        send_check(1'b1, 9'h007, 3, 1'b1, 2'b10, -1, "t3_7o2");

        // Divisor clamp
        send_check(1'b0, 9'($urandom), 0, 1'b0, 2'b00, -1, "t4_div0");
        send_check(1'b0, 9'($urandom), 1, 1'b1, 2'b01, -1, "t4_div1");

        // Divisor change mid-frame, then the new divisor
        send_check(1'b0, 9'h0C3, 6, 1'b0, 2'b00, 10, "t5_div6");
        send_check(1'b0, 9'h01E, 10, 1'b0, 2'b00, -1, "t5_div10");

        // Reset during data bit 3 (cycles 16..19 at div 4)
        @(negedge clk);
        sel = 1'b0; div = 16'd4; two_stop = 1'b0; pm = 2'b00; data8 = 8'hFF; stb8 = 1'b1;
        @(posedge clk); #1;
        chk("t6_ack", 32'(ack_o), 32'd1);
        stb8 = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        chk("t6_busy_before_rst", 32'(busy_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_tx", 32'(tx_o), 32'd1);
        chk("t6_rst_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_check(1'b0, 9'h096, 4, 1'b0, 2'b00, -1, "t6_after_rst");

        // Random frames on both widths
        for (int i = 0; i < 6; i++) begin
            rd = 9'($urandom);
            send_check(1'b0, rd, int'($urandom_range(0, 9)), 1'($urandom), 2'($urandom), -1, "rnd8");
        end
        for (int i = 0; i < 4; i++) begin
            rd = 9'($urandom);
            send_check(1'b1, rd, int'($urandom_range(0, 7)), 1'($urandom), 2'($urandom), -1, "rnd7");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
